// File: rtl/ipr_pkg.sv
// Shared types and helpers for the IPR request router.
//   ipr_route_t      : route tag held per outstanding transaction
//   IPR_CH_W_MAX     : widest channel-select field a tag can carry
//   IPR_TIMEOUT_DATA : read data returned by a synthetic timeout response
//   ipr_decode()     : address-window match
package ipr_pkg;

    // Tags carry a fixed-width channel field so the type can live in a
    // package; the router uses only the low $clog2(NUM_CH) bits.
    localparam int IPR_CH_W_MAX = 8;

    localparam logic [31:0] IPR_TIMEOUT_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic                    is_ipr;
        logic                    we;
        logic [IPR_CH_W_MAX-1:0] chan;
    } ipr_route_t;

    function automatic logic ipr_decode(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/ipr_route_fifo.sv
// In-order tracker of route tags for accepted transactions.
// Ports:
//   clk, rst_n      : clock, async active-low reset (empties the FIFO)
//   push, din       : write a tag (ignored when full)
//   pop             : drop the head tag (ignored when empty)
//   dout            : head tag
//   full, empty     : occupancy flags
//   count           : number of stored tags
module ipr_route_fifo
    import ipr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  ipr_route_t                 din,
    input  logic                       pop,
    output ipr_route_t                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    ipr_route_t     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ipr_router.sv
// Routes core data-memory requests to the default memory path or to one of
// NUM_CH IPR read/write channel pairs, and steers responses back in order.
// Optional build macro: IPR_TIMEOUT_EN (synthetic response after
// TIMEOUT_CYCLES without a head response).
// Ports:
//   clk, rst_n                          : clock, async active-low reset
//   data_req_i/addr/wdata/we/be         : core request
//   data_gnt_o/rvalid/rdata             : core grant and response
//   bus_addr/wdata/we/be_o              : request fields broadcast to targets
//   dflt_req/gnt/rvalid/rdata           : default memory path
//   ipr_rd_req/gnt/rvalid/rdata         : IPR read channels (rdata c at [c*DATA_W +: DATA_W])
//   ipr_wr_req/gnt/rvalid               : IPR write channels
//   outstanding_o                       : tracked transaction count
//   err_o                               : stray response or timeout pulse
module ipr_router
    import ipr_pkg::*;
#(
    parameter int          NUM_CH          = 4,
    parameter int          DATA_W          = 32,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [31:0] IPR_BASE        = 32'h1900_0000,
    parameter logic [31:0] IPR_MASK        = 32'hFF00_0000,
    parameter int          CH_SEL_LSB      = 4,
    parameter int          TIMEOUT_CYCLES  = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              data_req_i,
    input  logic [31:0]                       data_addr_i,
    input  logic [DATA_W-1:0]                 data_wdata_i,
    input  logic                              data_we_i,
    input  logic [DATA_W/8-1:0]               data_be_i,
    output logic                              data_gnt_o,
    output logic                              data_rvalid_o,
    output logic [DATA_W-1:0]                 data_rdata_o,
    output logic [31:0]                       bus_addr_o,
    output logic [DATA_W-1:0]                 bus_wdata_o,
    output logic                              bus_we_o,
    output logic [DATA_W/8-1:0]               bus_be_o,
    output logic                              dflt_req_o,
    input  logic                              dflt_gnt_i,
    input  logic                              dflt_rvalid_i,
    input  logic [DATA_W-1:0]                 dflt_rdata_i,
    output logic [NUM_CH-1:0]                 ipr_rd_req_o,
    input  logic [NUM_CH-1:0]                 ipr_rd_gnt_i,
    input  logic [NUM_CH-1:0]                 ipr_rd_rvalid_i,
    input  logic [NUM_CH*DATA_W-1:0]          ipr_rd_rdata_i,
    output logic [NUM_CH-1:0]                 ipr_wr_req_o,
    input  logic [NUM_CH-1:0]                 ipr_wr_gnt_i,
    input  logic [NUM_CH-1:0]                 ipr_wr_rvalid_i,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding_o,
    output logic                              err_o
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam int RV_W = 2*NUM_CH + 1;

    if (NUM_CH < 2 || (NUM_CH & (NUM_CH-1)) != 0 || CH_W > IPR_CH_W_MAX) begin : g_chk_ch
        $error("ipr_router: NUM_CH must be a power of 2, >= 2 and fit a route tag");
    end
    if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING-1)) != 0) begin : g_chk_mo
        $error("ipr_router: MAX_OUTSTANDING must be a power of 2, >= 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_chk_to
        $error("ipr_router: TIMEOUT_CYCLES must be >= 2");
    end

    logic              is_ipr;
    logic [CH_W-1:0]   sel;
    logic              tgt_gnt;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    ipr_route_t        push_tag;
    ipr_route_t        head_tag;
    logic [CH_W-1:0]   head_ch;
    logic [RV_W-1:0]   rv_all;
    logic [RV_W-1:0]   head_mask;
    logic              head_rvalid;
    logic              stray;
    logic [DATA_W-1:0] head_rdata;
    logic              timeout_fire;
    logic              unused_chan;

    assign bus_addr_o  = data_addr_i;
    assign bus_wdata_o = data_wdata_i;
    assign bus_we_o    = data_we_i;
    assign bus_be_o    = data_be_i;

    assign is_ipr = data_req_i && ipr_decode(data_addr_i, IPR_BASE, IPR_MASK);
    assign sel    = data_addr_i[CH_SEL_LSB +: CH_W];

    // A full tracker blocks every request, even if the head pops this cycle,
    // so the push never depends on the same-cycle response path.
    always_comb begin
        dflt_req_o   = 1'b0;
        ipr_rd_req_o = '0;
        ipr_wr_req_o = '0;
        tgt_gnt      = 1'b0;
        if (data_req_i) begin
            if (is_ipr) begin
                if (data_we_i) begin
                    ipr_wr_req_o[sel] = !full;
                    tgt_gnt           = ipr_wr_gnt_i[sel];
                end else begin
                    ipr_rd_req_o[sel] = !full;
                    tgt_gnt           = ipr_rd_gnt_i[sel];
                end
            end else begin
                dflt_req_o = !full;
                tgt_gnt    = dflt_gnt_i;
            end
        end
    end

    assign data_gnt_o = data_req_i && !full && tgt_gnt;
    assign push       = data_gnt_o;

    always_comb begin
        push_tag        = '0;
        push_tag.is_ipr = is_ipr;
        push_tag.we     = data_we_i;
        push_tag.chan   = IPR_CH_W_MAX'(sel);
    end

    ipr_route_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_tag),
        .pop   (pop),
        .dout  (head_tag),
        .full  (full),
        .empty (empty),
        .count (outstanding_o)
    );

    assign head_ch     = head_tag.chan[CH_W-1:0];
    assign unused_chan = ^head_tag.chan;

    // rv_all bit layout: [0] default, [1 +: NUM_CH] read, [1+NUM_CH +: NUM_CH] write.
    assign rv_all = {ipr_wr_rvalid_i, ipr_rd_rvalid_i, dflt_rvalid_i};

    always_comb begin
        head_mask = '0;
        if (!empty) begin
            if (!head_tag.is_ipr)  head_mask[0]                 = 1'b1;
            else if (head_tag.we)  head_mask[1+NUM_CH+head_ch]  = 1'b1;
            else                   head_mask[1+head_ch]         = 1'b1;
        end
    end

    assign head_rvalid = |(rv_all & head_mask);
    assign stray       = |(rv_all & ~head_mask);

    always_comb begin
        head_rdata = dflt_rdata_i;
        if (head_tag.is_ipr) begin
            head_rdata = head_tag.we ? '0 : ipr_rd_rdata_i[head_ch*DATA_W +: DATA_W];
        end
    end

`ifdef IPR_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] wait_cnt;

    assign timeout_fire = !empty && !head_rvalid &&
                          (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (pop || (push && empty)) begin
            wait_cnt <= '0;
        end else if (!empty) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    assign pop           = head_rvalid || timeout_fire;
    assign data_rvalid_o = pop;
    assign err_o         = stray || timeout_fire;

    always_comb begin
        data_rdata_o = '0;
        if (timeout_fire)     data_rdata_o = DATA_W'(IPR_TIMEOUT_DATA);
        else if (head_rvalid) data_rdata_o = head_rdata;
    end

endmodule

// File: tb/tb_ipr_router.sv
// Directed self-checking bench for ipr_router (NUM_CH=4, DATA_W=32,
// MAX_OUTSTANDING=4). Inputs are driven 1 ns after the rising edge and
// outputs are sampled on the falling edge.
module tb_ipr_router;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int MO     = 4;
`ifdef IPR_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 1024;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     data_req_i;
    logic [31:0]              data_addr_i;
    logic [DATA_W-1:0]        data_wdata_i;
    logic                     data_we_i;
    logic [DATA_W/8-1:0]      data_be_i;
    logic                     data_gnt_o;
    logic                     data_rvalid_o;
    logic [DATA_W-1:0]        data_rdata_o;
    logic [31:0]              bus_addr_o;
    logic [DATA_W-1:0]        bus_wdata_o;
    logic                     bus_we_o;
    logic [DATA_W/8-1:0]      bus_be_o;
    logic                     dflt_req_o;
    logic                     dflt_gnt_i;
    logic                     dflt_rvalid_i;
    logic [DATA_W-1:0]        dflt_rdata_i;
    logic [NUM_CH-1:0]        ipr_rd_req_o;
    logic [NUM_CH-1:0]        ipr_rd_gnt_i;
    logic [NUM_CH-1:0]        ipr_rd_rvalid_i;
    logic [NUM_CH*DATA_W-1:0] ipr_rd_rdata_i;
    logic [NUM_CH-1:0]        ipr_wr_req_o;
    logic [NUM_CH-1:0]        ipr_wr_gnt_i;
    logic [NUM_CH-1:0]        ipr_wr_rvalid_i;
    logic [$clog2(MO):0]      outstanding_o;
    logic                     err_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ipr_router #(
        .NUM_CH          (NUM_CH),
        .DATA_W          (DATA_W),
        .MAX_OUTSTANDING (MO),
        .TIMEOUT_CYCLES  (TO_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_req_i      (data_req_i),
        .data_addr_i     (data_addr_i),
        .data_wdata_i    (data_wdata_i),
        .data_we_i       (data_we_i),
        .data_be_i       (data_be_i),
        .data_gnt_o      (data_gnt_o),
        .data_rvalid_o   (data_rvalid_o),
        .data_rdata_o    (data_rdata_o),
        .bus_addr_o      (bus_addr_o),
        .bus_wdata_o     (bus_wdata_o),
        .bus_we_o        (bus_we_o),
        .bus_be_o        (bus_be_o),
        .dflt_req_o      (dflt_req_o),
        .dflt_gnt_i      (dflt_gnt_i),
        .dflt_rvalid_i   (dflt_rvalid_i),
        .dflt_rdata_i    (dflt_rdata_i),
        .ipr_rd_req_o    (ipr_rd_req_o),
        .ipr_rd_gnt_i    (ipr_rd_gnt_i),
        .ipr_rd_rvalid_i (ipr_rd_rvalid_i),
        .ipr_rd_rdata_i  (ipr_rd_rdata_i),
        .ipr_wr_req_o    (ipr_wr_req_o),
        .ipr_wr_gnt_i    (ipr_wr_gnt_i),
        .ipr_wr_rvalid_i (ipr_wr_rvalid_i),
        .outstanding_o   (outstanding_o),
        .err_o           (err_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_req_i      = 1'b0;
        data_addr_i     = '0;
        data_wdata_i    = '0;
        data_we_i       = 1'b0;
        data_be_i       = '0;
        dflt_gnt_i      = 1'b0;
        dflt_rvalid_i   = 1'b0;
        dflt_rdata_i    = '0;
        ipr_rd_gnt_i    = '0;
        ipr_rd_rvalid_i = '0;
        ipr_rd_rdata_i  = '0;
        ipr_wr_gnt_i    = '0;
        ipr_wr_rvalid_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int d;
        int early;

        // Reset state
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_gnt",         data_gnt_o,    0);
        check("rst_rvalid",      data_rvalid_o, 0);
        check("rst_rdata",       data_rdata_o,  0);
        check("rst_err",         err_o,         0);
        check("rst_reqs",        {dflt_req_o, ipr_rd_req_o, ipr_wr_req_o}, 0);
        step();
        rst_n = 1'b1;

        // Single IPR read: 0x1900_0020 selects channel 2
        step();
        data_req_i   = 1'b1;
        data_addr_i  = 32'h1900_0020;
        data_wdata_i = 32'h0BAD_F00D;
        data_be_i    = 4'hF;
        ipr_rd_gnt_i = 4'b0100;
        @(negedge clk);
        check("t1_rd_req",   ipr_rd_req_o, 4'b0100);
        check("t1_other_rq", {dflt_req_o, ipr_wr_req_o}, 0);
        check("t1_gnt",      data_gnt_o, 1);
        check("t1_bus_addr", bus_addr_o, 32'h1900_0020);
        check("t1_bus_wd",   bus_wdata_o, 32'h0BAD_F00D);
        step();
        idle();
        @(negedge clk);
        check("t1_outst1", outstanding_o, 1);
        repeat (2) step();
        ipr_rd_rvalid_i              = 4'b0100;
        ipr_rd_rdata_i[2*DATA_W +: DATA_W] = 32'hA5A5_0002;
        ipr_rd_rdata_i[1*DATA_W +: DATA_W] = 32'h1111_1111;
        @(negedge clk);
        check("t1_rvalid", data_rvalid_o, 1);
        check("t1_rdata",  data_rdata_o, 32'hA5A5_0002);
        check("t1_err",    err_o, 0);
        step();
        idle();
        @(negedge clk);
        check("t1_outst0", outstanding_o, 0);

        // Back-to-back: default read, IPR write ch1, IPR read ch3
        step();
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_1000;
        dflt_gnt_i  = 1'b1;
        @(negedge clk);
        check("t2_dflt_req", dflt_req_o, 1);
        check("t2_dflt_gnt", data_gnt_o, 1);
        step();
        dflt_gnt_i   = 1'b0;
        data_addr_i  = 32'h1900_0010;
        data_we_i    = 1'b1;
        ipr_wr_gnt_i = 4'b0010;
        @(negedge clk);
        check("t2_wr_req", {dflt_req_o, ipr_rd_req_o, ipr_wr_req_o}, 9'b0_0000_0010);
        check("t2_wr_gnt", data_gnt_o, 1);
        step();
        ipr_wr_gnt_i = '0;
        data_addr_i  = 32'h1900_0030;
        data_we_i    = 1'b0;
        ipr_rd_gnt_i = 4'b1000;
        @(negedge clk);
        check("t2_rd_req", {dflt_req_o, ipr_rd_req_o, ipr_wr_req_o}, 9'b0_1000_0000);
        step();
        idle();
        @(negedge clk);
        check("t2_outst3", outstanding_o, 3);

        d = $urandom_range(5, 1);
        repeat (d - 1) step();
        idle();
        dflt_rvalid_i = 1'b1;
        dflt_rdata_i  = 32'h1234_5678;
        @(negedge clk);
        check("t2_dflt_rv", data_rvalid_o, 1);
        check("t2_dflt_rd", data_rdata_o, 32'h1234_5678);
        d = $urandom_range(5, 1);
        repeat (d) step();
        idle();
        ipr_wr_rvalid_i = 4'b0010;
        dflt_rdata_i    = 32'hFFFF_FFFF;
        ipr_rd_rdata_i  = '1;
        @(negedge clk);
        check("t2_wr_rv",  data_rvalid_o, 1);
        check("t2_wr_rd0", data_rdata_o, 0);
        check("t2_wr_err", err_o, 0);
        d = $urandom_range(5, 1);
        repeat (d) step();
        idle();
        ipr_rd_rvalid_i = 4'b1000;
        ipr_rd_rdata_i[3*DATA_W +: DATA_W] = 32'hC3C3_0003;
        @(negedge clk);
        check("t2_rd_rv", data_rvalid_o, 1);
        check("t2_rd_rd", data_rdata_o, 32'hC3C3_0003);
        step();
        idle();
        @(negedge clk);
        check("t2_outst0", outstanding_o, 0);

        // Fill the tracker, then back-pressure
        step();
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_2000;
        dflt_gnt_i  = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("t3_full",      outstanding_o, 4);
        check("t3_bp_req",    {dflt_req_o, ipr_rd_req_o, ipr_wr_req_o}, 0);
        check("t3_bp_gnt",    data_gnt_o, 0);
        dflt_rvalid_i = 1'b1;
        dflt_rdata_i  = 32'h0000_00F1;
        #1;
        check("t3_pop_rv",    data_rvalid_o, 1);
        check("t3_pop_nogn",  data_gnt_o, 0);
        step();
        dflt_rvalid_i = 1'b0;
        @(negedge clk);
        check("t3_outst3",    outstanding_o, 3);
        check("t3_regnt",     data_gnt_o, 1);
        check("t3_rereq",     dflt_req_o, 1);
        step();
        data_req_i    = 1'b0;
        dflt_gnt_i    = 1'b0;
        dflt_rvalid_i = 1'b1;
        @(negedge clk);
        check("t3_refull",    outstanding_o, 4);
        repeat (4) step();
        dflt_rvalid_i = 1'b0;
        @(negedge clk);
        check("t3_drained",   outstanding_o, 0);

        // Stray response while empty
        step();
        ipr_rd_rvalid_i = 4'b0010;
        @(negedge clk);
        check("t4_stray_rv",  data_rvalid_o, 0);
        check("t4_stray_err", err_o, 1);
        step();
        idle();
        @(negedge clk);
        check("t4_err_clr",   err_o, 0);

        // Stray response from a non-head target
        step();
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_3000;
        dflt_gnt_i  = 1'b1;
        step();
        idle();
        ipr_rd_rvalid_i = 4'b0001;
        @(negedge clk);
        check("t4_nh_err",    err_o, 1);
        check("t4_nh_rv",     data_rvalid_o, 0);
        check("t4_nh_outst",  outstanding_o, 1);
        step();
        idle();
        dflt_rvalid_i = 1'b1;
        dflt_rdata_i  = 32'h0000_0055;
        @(negedge clk);
        check("t4_head_rd",   data_rdata_o, 32'h0000_0055);
        check("t4_head_err",  err_o, 0);
        step();
        idle();
        @(negedge clk);
        check("t4_outst0",    outstanding_o, 0);

`ifdef IPR_TIMEOUT_EN
        // Unanswered IPR read to ch0 times out after 16 cycles
        step();
        data_req_i   = 1'b1;
        data_addr_i  = 32'h1900_0000;
        ipr_rd_gnt_i = 4'b0001;
        step();
        idle();
        early = 0;
        @(negedge clk);
        if (data_rvalid_o !== 1'b0) early++;
        repeat (14) begin
            step();
            @(negedge clk);
            if (data_rvalid_o !== 1'b0) early++;
        end
        check("t5_no_early",  early, 0);
        step();
        @(negedge clk);
        check("t5_to_rv",     data_rvalid_o, 1);
        check("t5_to_rd",     data_rdata_o, 32'hDEAD_BEEF);
        check("t5_to_err",    err_o, 1);
        step();
        @(negedge clk);
        check("t5_outst0",    outstanding_o, 0);
        ipr_rd_rvalid_i = 4'b0001;
        #1;
        check("t5_late_err",  err_o, 1);
        check("t5_late_rv",   data_rvalid_o, 0);
        step();
        idle();
`endif

        // Asynchronous reset with two outstanding
        step();
        data_req_i  = 1'b1;
        data_addr_i = 32'h0000_4000;
        dflt_gnt_i  = 1'b1;
        repeat (2) step();
        idle();
        @(negedge clk);
        check("t6_outst2",    outstanding_o, 2);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_async_cnt", outstanding_o, 0);
        check("t6_async_out", {data_gnt_o, data_rvalid_o, err_o, dflt_req_o,
                               ipr_rd_req_o, ipr_wr_req_o, data_rdata_o}, 0);
        step();
        rst_n = 1'b1;
        step();
        dflt_rvalid_i = 1'b1;
        @(negedge clk);
        check("t6_post_err",  err_o, 1);
        check("t6_post_rv",   data_rvalid_o, 0);
        step();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ipr_router.md
Name: ipr_router

Overview:
- Parametrised successor of the single-transaction IPR decoder between the core data-memory port and the inter-processor (IPR) fabric.
- Routes each core request either to the default memory path or to one of NUM_CH read/write IPR channel pairs.
- Tracks up to MAX_OUTSTANDING accepted transactions in order, so every response is steered from the correct source.
- Sits between the core LSU and the tile's memory/IPR ports.

Parameters:
- NUM_CH, 4, number of IPR channels; power of 2, at least 2. CH_W = $clog2(NUM_CH).
- DATA_W, 32, data width. Address width is fixed at 32.
- MAX_OUTSTANDING, 4, depth of the in-order response tracker; power of 2, at least 2.
- IPR_BASE, 32'h1900_0000, IPR window base.
- IPR_MASK, 32'hFF00_0000, mask; a request is IPR when (addr & IPR_MASK) == IPR_BASE.
- CH_SEL_LSB, 4, LSB of the channel-select field addr[CH_SEL_LSB+CH_W-1:CH_SEL_LSB].
- TIMEOUT_CYCLES, 1024, response timeout, used only when IPR_TIMEOUT_EN is defined.

Ports:
- clk in 1: clock.
- rst_n in 1: reset, asynchronous, active-low.
- data_req_i in 1, data_addr_i in 32, data_wdata_i in DATA_W, data_we_i in 1, data_be_i in DATA_W/8: core request.
- data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out DATA_W: core response.
- bus_addr_o out 32, bus_wdata_o out DATA_W, bus_we_o out 1, bus_be_o out DATA_W/8: broadcast request fields to all targets.
- dflt_req_o out 1, dflt_gnt_i in 1, dflt_rvalid_i in 1, dflt_rdata_i in DATA_W: default path.
- ipr_rd_req_o out NUM_CH, ipr_rd_gnt_i in NUM_CH, ipr_rd_rvalid_i in NUM_CH, ipr_rd_rdata_i in NUM_CH*DATA_W: IPR read channels, channel c at rdata slice [c*DATA_W +: DATA_W].
- ipr_wr_req_o out NUM_CH, ipr_wr_gnt_i in NUM_CH, ipr_wr_rvalid_i in NUM_CH: IPR write channels.
- outstanding_o out $clog2(MAX_OUTSTANDING)+1: number of tracked transactions.
- err_o out 1: one-cycle pulse on a protocol error.

Behaviour:
- Reset values: all req outputs 0, data_gnt_o 0, data_rvalid_o 0, data_rdata_o 0, outstanding_o 0, err_o 0. The tracker is emptied.
- Bus fields are combinational copies of the core request fields.
- Decode is combinational. is_ipr = data_req_i & window match. sel = channel-select field.
- Request steering:
  - IPR write request: ipr_wr_req_o[sel] = 1.
  - IPR read request: ipr_rd_req_o[sel] = 1.
  - Non-IPR request: dflt_req_o = 1.
  - At most one req output is high in any cycle.
- When the tracker is full, every req output and data_gnt_o is forced to 0 (back-pressure). A pop in the same cycle does not lift this.
- data_gnt_o is combinational: the gnt of the selected target.
- Acceptance: req & gnt. On acceptance, push a route tag {is_ipr, we, chan} into the tracker in the same cycle. Zero added request latency.
- Response: data_rvalid_o follows the rvalid of the target named by the head tag. The head tag is popped when that rvalid is high.
  - Read response: data_rdata_o = that target's rdata.
  - IPR write response: data_rdata_o = 0.
  - Default response: dflt_rdata_i is passed through unchanged.
  - Response latency is 0 cycles (combinational).
- Simultaneous push and pop is legal when the tracker is not full. outstanding_o is unchanged in that case.
- A response arriving in the same cycle as its own grant cannot occur, because targets respond at least 1 cycle after grant.
- Stray rvalid: an rvalid from any target other than the head, or any rvalid while the tracker is empty. It is dropped, and err_o pulses for 1 cycle.
- Tracker pointers wrap modulo MAX_OUTSTANDING. Full and empty are distinguished by the extra count bit.
- Reset mid-operation discards all tracked tags. Responses still in flight afterwards are treated as stray.

Optional Feature:
- Macro: IPR_TIMEOUT_EN.
- Defined:
  - A wait counter clears on every pop or push-into-empty, and increments while the tracker is non-empty with no head response.
  - When it reaches TIMEOUT_CYCLES-1, the router emits a synthetic data_rvalid_o with data_rdata_o = 32'hDEAD_BEEF (zero-extended to DATA_W), pops the head, and pulses err_o.
  - A late real response for that transaction is then stray.
- Undefined: no counter; the router waits indefinitely.

Decomposition:
- Package ipr_pkg holds:
  - typedef ipr_route_t {logic is_ipr; logic we; logic [CH_W-1:0] chan}.
  - localparam IPR_TIMEOUT_DATA = 32'hDEAD_BEEF.
  - function ipr_decode(addr, base, mask).
- Sub-module ipr_route_fifo: a synchronous FIFO of ipr_route_t with push, pop, full, empty and count outputs. The remaining logic stays in ipr_router.

Test Plan:
- Read of 0x1900_0020 with NUM_CH=4 -> ipr_rd_req_o=4'b0100; gnt; 3 cycles later rdata[2]=0xA5A5_0002 with rvalid -> data_rdata_o=0xA5A5_0002, outstanding_o 1->0.
- Back-to-back accepted transactions: default read, IPR write ch1, IPR read ch3; responses arrive in order with 1-5 cycle random delays -> each data_rvalid_o carries the correct data; IPR write returns rdata 0.
- Fill to MAX_OUTSTANDING=4 with no responses -> 5th request sees all req outputs 0 and data_gnt_o 0. After one response, the request is granted on the next cycle.
- Stray ipr_rd_rvalid_i[1] with the tracker empty -> data_rvalid_o stays 0; err_o pulses once.
- With IPR_TIMEOUT_EN and TIMEOUT_CYCLES=16, IPR read to ch0 never answered -> after 16 cycles data_rvalid_o=1, data_rdata_o=0xDEAD_BEEF, err_o=1; a later real rvalid pulses err_o again.
- Assert rst_n low with 2 outstanding -> all outputs 0 and outstanding_o=0 immediately (asynchronous).
